// File: rtl/waveform_pkg.sv
// -----------------------------------------------------------------------------
// waveform_pkg
// Shared types and reset-default configuration for the programmable waveform
// generator.
//   mode_t : waveform shape selected by cfg_mode
//   dir_t  : ramp direction / square phase reported on the dir output
// The reset-default constants make the generator run the classic full-scale
// triangle (step 1, lo 0, hi all-ones) without any configuration.
// -----------------------------------------------------------------------------
package waveform_pkg;

   typedef enum logic [1:0] {
      TRIANGLE = 2'd0,
      SAW_UP   = 2'd1,
      SAW_DOWN = 2'd2,
      SQUARE   = 2'd3
   } mode_t;

   typedef enum logic {
      DOWN = 1'b0,
      UP   = 1'b1
   } dir_t;

   localparam mode_t       RST_MODE = TRIANGLE;
   localparam dir_t        RST_DIR  = UP;
   localparam int unsigned RST_STEP = 1;
   localparam int unsigned RST_LO   = 0;
   // hi resets to all-ones; width depends on N, so it is built in the top.

   // Every 2-bit code is legal; anything not explicitly listed is a triangle.
   function automatic mode_t decode_mode(input logic [1:0] code);
      mode_t m;
      case (code)
         2'd1:    m = SAW_UP;
         2'd2:    m = SAW_DOWN;
         2'd3:    m = SQUARE;
         default: m = TRIANGLE;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/waveform_sat_step.sv
// -----------------------------------------------------------------------------
// sat_step
// Combinational bounded step used by all ramp modes.
//   a        : current sample
//   step     : unsigned step size
//   lo, hi   : inclusive bounds
//   sub      : nominal direction of the move (1 = towards lo, 0 = towards hi)
//   y        : next sample, clamped into [lo, hi]
//   at_limit : a already sits on the bound it is moving towards
// When at_limit is set the move is reflected (bounce off the bound), which is
// exactly the turnaround value a triangle needs; saw modes ignore y in that
// case and jump to the opposite bound instead.
// Sums and differences are N+1 bits wide so an N-bit overflow/borrow is
// caught and saturated instead of wrapping.
// -----------------------------------------------------------------------------
module sat_step #(
   parameter int N = 8
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] step,
   input  logic [N-1:0] lo,
   input  logic [N-1:0] hi,
   input  logic         sub,
   output logic [N-1:0] y,
   output logic         at_limit
);

   logic [N:0] sum;
   logic [N:0] diff;
   logic       move_down;

   assign at_limit  = sub ? (a == lo) : (a == hi);
   assign move_down = sub ^ at_limit;

   assign sum  = {1'b0, a} + {1'b0, step};
   assign diff = {1'b0, a} - {1'b0, step};

   always_comb begin
      if (move_down) begin
         // diff[N] is the borrow: the true result went below zero.
         if (diff[N] || (diff[N-1:0] <= lo)) begin
            y = lo;
         end else begin
            y = diff[N-1:0];
         end
      end else begin
         if (sum >= {1'b0, hi}) begin
            y = hi;
         end else begin
            y = sum[N-1:0];
         end
      end
   end

endmodule

// File: rtl/waveform_generator.sv
// -----------------------------------------------------------------------------
// waveform_generator
// Programmable periodic waveform source: triangle, sawtooth up, sawtooth down
// and square, with programmable step and inclusive lo/hi bounds.
// Ports:
//   clk      : system clock
//   rst      : asynchronous active-high reset
//   ena      : advance one step this cycle, hold otherwise
//   cfg_load : latch cfg_* and restart the waveform (wins over ena)
//   cfg_mode : 0 triangle, 1 saw up, 2 saw down, 3 square
//   cfg_step : unsigned increment per enabled cycle
//   cfg_lo   : lower bound (inclusive)
//   cfg_hi   : upper bound (inclusive)
//   out      : registered waveform sample
//   dir      : 1 counting up / square high, 0 counting down / square low
//   wrap     : one-cycle pulse, a new period started
//   cfg_err  : latched configuration error (lo >= hi)
// All outputs are registers; nothing combinational reaches an output.
// -----------------------------------------------------------------------------
module waveform_generator
   import waveform_pkg::*;
#(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ena,
   input  logic         cfg_load,
   input  logic [1:0]   cfg_mode,
   input  logic [N-1:0] cfg_step,
   input  logic [N-1:0] cfg_lo,
   input  logic [N-1:0] cfg_hi,
   output logic [N-1:0] out,
   output logic         dir,
   output logic         wrap,
   output logic         cfg_err
);

   localparam logic [N-1:0] RST_STEP_N = N'(RST_STEP);
   localparam logic [N-1:0] RST_LO_N   = N'(RST_LO);
   localparam logic [N-1:0] RST_HI_N   = '1;

   mode_t        mode_q, mode_d;
   logic [N-1:0] step_q, step_d;
   logic [N-1:0] lo_q,   lo_d;
   logic [N-1:0] hi_q,   hi_d;
   logic [N-1:0] out_q,  out_d;
   dir_t         dir_q,  dir_d;
   logic         wrap_q, wrap_d;
   logic         err_q,  err_d;
   logic [N-1:0] acc_q,  acc_d;

   logic         sat_sub;
   logic [N-1:0] sat_y;
   logic         sat_lim;

   logic [N:0]   acc_sum;
   logic         sq_high;
   logic         sq_next_high;

   // Nominal move direction for the shared stepper. Square mode does not use
   // the stepper, so its value there is irrelevant.
   always_comb begin
      case (mode_q)
         SAW_UP:   sat_sub = 1'b0;
         SAW_DOWN: sat_sub = 1'b1;
         default:  sat_sub = (dir_q == DOWN);
      endcase
   end

   sat_step #(.N(N)) u_sat_step (
      .a        (out_q),
      .step     (step_q),
      .lo       (lo_q),
      .hi       (hi_q),
      .sub      (sat_sub),
      .y        (sat_y),
      .at_limit (sat_lim)
   );

   // Square phase is taken from the sample itself rather than from dir: right
   // after cfg_load dir reads 1 while out sits at lo, and the first enabled
   // edge must settle dir to the low phase.
   assign acc_sum      = {1'b0, acc_q} + {1'b0, step_q};
   assign sq_high      = (out_q == hi_q);
   assign sq_next_high = acc_sum[N] ? !sq_high : sq_high;

   always_comb begin
      mode_d = mode_q;
      step_d = step_q;
      lo_d   = lo_q;
      hi_d   = hi_q;
      out_d  = out_q;
      dir_d  = dir_q;
      acc_d  = acc_q;
      err_d  = err_q;
      wrap_d = 1'b0;

      if (cfg_load) begin
         mode_d = decode_mode(cfg_mode);
         step_d = cfg_step;
         lo_d   = cfg_lo;
         hi_d   = cfg_hi;
         out_d  = cfg_lo;
         dir_d  = UP;
         acc_d  = '0;
         err_d  = (cfg_lo >= cfg_hi);
      end else if (ena && !err_q && (step_q != '0)) begin
         // A zero step freezes every mode, including the saw-down restart
         // jump, so no wrap can ever fire with step=0.
         case (mode_q)
            SAW_UP: begin
               dir_d = UP;
               if (sat_lim) begin
                  out_d  = lo_q;
                  wrap_d = 1'b1;
               end else begin
                  out_d = sat_y;
               end
            end
            SAW_DOWN: begin
               dir_d = DOWN;
               if (sat_lim) begin
                  out_d  = hi_q;
                  wrap_d = 1'b1;
               end else begin
                  out_d = sat_y;
               end
            end
            SQUARE: begin
               acc_d  = acc_sum[N-1:0];
               dir_d  = sq_next_high ? UP : DOWN;
               out_d  = sq_next_high ? hi_q : lo_q;
               wrap_d = acc_sum[N] && !sq_high;
            end
            default: begin
               // Triangle: sat_step already reflects off the bound, so only
               // the direction flip and the wrap at the bottom are added here.
               out_d = sat_y;
               if (sat_lim) begin
                  dir_d  = (dir_q == UP) ? DOWN : UP;
                  wrap_d = (dir_q == DOWN);
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q <= RST_MODE;
         step_q <= RST_STEP_N;
         lo_q   <= RST_LO_N;
         hi_q   <= RST_HI_N;
         out_q  <= '0;
         dir_q  <= RST_DIR;
         wrap_q <= 1'b0;
         err_q  <= 1'b0;
         acc_q  <= '0;
      end else begin
         mode_q <= mode_d;
         step_q <= step_d;
         lo_q   <= lo_d;
         hi_q   <= hi_d;
         out_q  <= out_d;
         dir_q  <= dir_d;
         wrap_q <= wrap_d;
         err_q  <= err_d;
         acc_q  <= acc_d;
      end
   end

   assign out     = out_q;
   assign dir     = dir_q;
   assign wrap    = wrap_q;
   assign cfg_err = err_q;

endmodule

// File: tb/tb_waveform_generator.sv
module tb_waveform_generator;

   localparam int N = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         ena;
   logic         cfg_load;
   logic [1:0]   cfg_mode;
   logic [N-1:0] cfg_step;
   logic [N-1:0] cfg_lo;
   logic [N-1:0] cfg_hi;
   logic [N-1:0] out;
   logic         dir;
   logic         wrap;
   logic         cfg_err;

   waveform_generator #(.N(N)) dut (
      .clk      (clk),
      .rst      (rst),
      .ena      (ena),
      .cfg_load (cfg_load),
      .cfg_mode (cfg_mode),
      .cfg_step (cfg_step),
      .cfg_lo   (cfg_lo),
      .cfg_hi   (cfg_hi),
      .out      (out),
      .dir      (dir),
      .wrap     (wrap),
      .cfg_err  (cfg_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] o;
      logic       d;
      logic       w;
      logic       e;
      string      nm;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_bad = 0;

   function automatic exp_t mk(input logic [7:0] o, input logic d, input logic w,
                               input logic e, input string nm);
      exp_t x;
      x.o  = o;
      x.d  = d;
      x.w  = w;
      x.e  = e;
      x.nm = nm;
      return x;
   endfunction

   function automatic void check(input exp_t x);
      n_vec++;
      if (out !== x.o || dir !== x.d || wrap !== x.w || cfg_err !== x.e) begin
         n_bad++;
         $display("FAIL %s: got out=%0d dir=%0b wrap=%0b cfg_err=%0b, expected out=%0d dir=%0b wrap=%0b cfg_err=%0b",
                  x.nm, out, dir, wrap, cfg_err, x.o, x.d, x.w, x.e);
      end
   endfunction

   // Monitor: one expected entry per clock, compared away from the active edge.
   always @(negedge clk) begin
      if (exp_q.size() > 0) check(exp_q.pop_front());
   end

   // One clock with cfg_load; output expected after the edge.
   task automatic load(input logic [1:0] m, input logic [7:0] st, input logic [7:0] lo,
                       input logic [7:0] hi, input logic e, input logic [7:0] eo,
                       input logic eerr, input string nm);
      cfg_load = 1'b1;
      ena      = e;
      cfg_mode = m;
      cfg_step = st;
      cfg_lo   = lo;
      cfg_hi   = hi;
      @(posedge clk);
      exp_q.push_back(mk(eo, 1'b1, 1'b0, eerr, nm));
      #1;
      cfg_load = 1'b0;
   endtask

   // One clock without cfg_load.
   task automatic run(input logic e, input logic [7:0] eo, input logic ed,
                      input logic ew, input logic eerr, input string nm);
      cfg_load = 1'b0;
      ena      = e;
      @(posedge clk);
      exp_q.push_back(mk(eo, ed, ew, eerr, nm));
      #1;
   endtask

   // Full-scale triangle from reset, k-th enabled edge.
   task automatic tri_exp(input int k, output logic [7:0] o, output logic d, output logic w);
      if (k <= 255) begin
         o = 8'(k); d = 1'b1; w = 1'b0;
      end else if (k <= 510) begin
         o = 8'(510 - k); d = 1'b0; w = 1'b0;
      end else begin
         o = 8'd1; d = 1'b1; w = 1'b1;
      end
   endtask

   initial begin
      logic [7:0] eo;
      logic       ed;
      logic       ew;

      rst      = 1'b1;
      ena      = 1'b0;
      cfg_load = 1'b0;
      cfg_mode = 2'd0;
      cfg_step = 8'd0;
      cfg_lo   = 8'd0;
      cfg_hi   = 8'd0;
      #1;
      exp_q.push_back(mk(8'd0, 1'b1, 1'b0, 1'b0, "reset_state"));
      @(negedge clk);
      #2;
      rst = 1'b0;

      // Default triangle, one full period plus the wrap.
      for (int k = 1; k <= 511; k++) begin
         tri_exp(k, eo, ed, ew);
         run(1'b1, eo, ed, ew, 1'b0, "default_tri");
      end

      // Bounded triangle, cfg_load with ena high, ena holes mid-ramp.
      load(2'd0, 8'd4, 8'd10, 8'd20, 1'b1, 8'd10, 1'b0, "tri_load_ena");
      run(1'b1, 8'd14, 1'b1, 1'b0, 1'b0, "tri_up");
      run(1'b0, 8'd14, 1'b1, 1'b0, 1'b0, "tri_hold");
      run(1'b0, 8'd14, 1'b1, 1'b0, 1'b0, "tri_hold");
      run(1'b1, 8'd18, 1'b1, 1'b0, 1'b0, "tri_up");
      run(1'b1, 8'd20, 1'b1, 1'b0, 1'b0, "tri_sat_hi");
      run(1'b1, 8'd16, 1'b0, 1'b0, 1'b0, "tri_turn_hi");
      run(1'b1, 8'd12, 1'b0, 1'b0, 1'b0, "tri_down");
      run(1'b1, 8'd10, 1'b0, 1'b0, 1'b0, "tri_sat_lo");
      run(1'b1, 8'd14, 1'b1, 1'b1, 1'b0, "tri_wrap");
      run(1'b0, 8'd14, 1'b1, 1'b0, 1'b0, "tri_wrap_clr");
      run(1'b1, 8'd18, 1'b1, 1'b0, 1'b0, "tri_up2");

      // Sawtooth up.
      load(2'd1, 8'd3, 8'd0, 8'd9, 1'b0, 8'd0, 1'b0, "saw_up_load");
      run(1'b1, 8'd3, 1'b1, 1'b0, 1'b0, "saw_up");
      run(1'b1, 8'd6, 1'b1, 1'b0, 1'b0, "saw_up");
      run(1'b1, 8'd9, 1'b1, 1'b0, 1'b0, "saw_up");
      run(1'b1, 8'd0, 1'b1, 1'b1, 1'b0, "saw_up_wrap");
      run(1'b1, 8'd3, 1'b1, 1'b0, 1'b0, "saw_up");

      // Sawtooth down (ena ignored on the load cycle).
      load(2'd2, 8'd3, 8'd0, 8'd9, 1'b1, 8'd0, 1'b0, "saw_dn_load");
      run(1'b1, 8'd9, 1'b0, 1'b1, 1'b0, "saw_dn_wrap");
      run(1'b1, 8'd6, 1'b0, 1'b0, 1'b0, "saw_dn");
      run(1'b1, 8'd3, 1'b0, 1'b0, 1'b0, "saw_dn");
      run(1'b1, 8'd0, 1'b0, 1'b0, 1'b0, "saw_dn");
      run(1'b1, 8'd9, 1'b0, 1'b1, 1'b0, "saw_dn_wrap");
      run(1'b1, 8'd6, 1'b0, 1'b0, 1'b0, "saw_dn");

      // Square, half-period ceil(256/64) = 4.
      load(2'd3, 8'd64, 8'd5, 8'd200, 1'b0, 8'd5, 1'b0, "sq_load");
      for (int i = 0; i < 3; i++) run(1'b1, 8'd5, 1'b0, 1'b0, 1'b0, "sq_lo_first");
      run(1'b1, 8'd200, 1'b1, 1'b1, 1'b0, "sq_rise_wrap");
      for (int i = 0; i < 3; i++) run(1'b1, 8'd200, 1'b1, 1'b0, 1'b0, "sq_hi");
      run(1'b1, 8'd5, 1'b0, 1'b0, 1'b0, "sq_fall");
      for (int i = 0; i < 3; i++) run(1'b1, 8'd5, 1'b0, 1'b0, 1'b0, "sq_lo");
      run(1'b1, 8'd200, 1'b1, 1'b1, 1'b0, "sq_rise_wrap2");

      // Zero step: everything holds, no wrap, even for saw down.
      load(2'd0, 8'd0, 8'd3, 8'd7, 1'b1, 8'd3, 1'b0, "step0_tri_load");
      run(1'b1, 8'd3, 1'b1, 1'b0, 1'b0, "step0_tri");
      run(1'b1, 8'd3, 1'b1, 1'b0, 1'b0, "step0_tri");
      load(2'd2, 8'd0, 8'd3, 8'd7, 1'b0, 8'd3, 1'b0, "step0_sd_load");
      run(1'b1, 8'd3, 1'b1, 1'b0, 1'b0, "step0_sd");
      run(1'b1, 8'd3, 1'b1, 1'b0, 1'b0, "step0_sd");

      // Configuration errors: lo == hi and lo > hi.
      load(2'd0, 8'd1, 8'd50, 8'd50, 1'b1, 8'd50, 1'b1, "err_eq_load");
      for (int i = 0; i < 3; i++) run(1'b1, 8'd50, 1'b1, 1'b0, 1'b1, "err_eq_hold");
      load(2'd1, 8'd1, 8'd60, 8'd40, 1'b0, 8'd60, 1'b1, "err_gt_load");
      run(1'b1, 8'd60, 1'b1, 1'b0, 1'b1, "err_gt_hold");

      // Large step: N+1-bit saturation, valid load clears the error.
      load(2'd0, 8'd200, 8'd0, 8'd255, 1'b0, 8'd0, 1'b0, "sat_tri_load");
      run(1'b1, 8'd200, 1'b1, 1'b0, 1'b0, "sat_tri_up");
      run(1'b1, 8'd255, 1'b1, 1'b0, 1'b0, "sat_tri_ovf");
      run(1'b1, 8'd55, 1'b0, 1'b0, 1'b0, "sat_tri_turn");
      run(1'b1, 8'd0, 1'b0, 1'b0, 1'b0, "sat_tri_borrow");
      run(1'b1, 8'd200, 1'b1, 1'b1, 1'b0, "sat_tri_wrap");
      load(2'd2, 8'd200, 8'd30, 8'd250, 1'b0, 8'd30, 1'b0, "sat_sd_load");
      run(1'b1, 8'd250, 1'b0, 1'b1, 1'b0, "sat_sd_wrap");
      run(1'b1, 8'd50, 1'b0, 1'b0, 1'b0, "sat_sd_down");
      run(1'b1, 8'd30, 1'b0, 1'b0, 1'b0, "sat_sd_borrow");
      run(1'b1, 8'd250, 1'b0, 1'b1, 1'b0, "sat_sd_wrap2");

      // Asynchronous reset between edges while square is high.
      load(2'd3, 8'd64, 8'd5, 8'd200, 1'b0, 8'd5, 1'b0, "sq2_load");
      for (int i = 0; i < 3; i++) run(1'b1, 8'd5, 1'b0, 1'b0, 1'b0, "sq2_lo");
      run(1'b1, 8'd200, 1'b1, 1'b1, 1'b0, "sq2_rise");
      run(1'b1, 8'd200, 1'b1, 1'b0, 1'b0, "sq2_hi");
      @(negedge clk);
      #1;
      ena = 1'b0;
      rst = 1'b1;
      #1;
      check(mk(8'd0, 1'b1, 1'b0, 1'b0, "async_rst"));
      @(posedge clk);
      @(negedge clk);
      #1;
      rst = 1'b0;

      // Defaults again after reset.
      for (int k = 1; k <= 300; k++) begin
         tri_exp(k, eo, ed, ew);
         run(1'b1, eo, ed, ew, 1'b0, "post_rst_tri");
      end

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
         n_vec++;
         n_bad++;
         $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
